// File: rtl/nx_node_instr_arbiter_if.sv
// nx_node_instr_arbiter_if: core fetch, store and instruction RAM signals
// shared between the arbiter and its neighbours.
`default_nettype none

interface nx_node_instr_arbiter_if #(
  parameter int RAM_ADDR_W = 10,
  parameter int RAM_DATA_W = 32
);
  logic [RAM_ADDR_W-1:0] i_core_addr;
  logic                  i_core_rd_en;
  logic [RAM_DATA_W-1:0] o_core_rd_data;
  logic                  o_core_stall;
  logic [RAM_ADDR_W-1:0] i_store_addr;
  logic [RAM_DATA_W-1:0] i_store_wr_data;
  logic                  i_store_wr;
  logic                  i_store_valid;
  logic                  o_store_ready;
  logic [RAM_DATA_W-1:0] o_store_rd_data;
  logic                  o_store_rd_valid;
  logic [RAM_ADDR_W-1:0] o_ram_addr;
  logic [RAM_DATA_W-1:0] o_ram_wr_data;
  logic                  o_ram_wr_en;
  logic                  o_ram_rd_en;
  logic [RAM_DATA_W-1:0] i_ram_rd_data;

  modport master (
    output i_core_addr, i_core_rd_en, i_store_addr, i_store_wr_data,
           i_store_wr, i_store_valid, i_ram_rd_data,
    input  o_core_rd_data, o_core_stall, o_store_ready, o_store_rd_data,
           o_store_rd_valid, o_ram_addr, o_ram_wr_data, o_ram_wr_en, o_ram_rd_en
  );

  modport slave (
    input  i_core_addr, i_core_rd_en, i_store_addr, i_store_wr_data,
           i_store_wr, i_store_valid, i_ram_rd_data,
    output o_core_rd_data, o_core_stall, o_store_ready, o_store_rd_data,
           o_store_rd_valid, o_ram_addr, o_ram_wr_data, o_ram_wr_en, o_ram_rd_en
  );
endinterface

`default_nettype wire

// File: rtl/nx_node_instr_arbiter.sv
//============================================================================
// Module  : nx_node_instr_arbiter
// Brief   : Core-priority arbiter for a single-port instruction RAM with a
//           one-entry store holding register and starvation-forced grant.
//           Optional NX_INSTR_ARB_STATS_EN adds a 16-bit stall counter.
// Rev     : 1.0
//============================================================================
`default_nettype none

module nx_node_instr_arbiter #(
  parameter int RAM_ADDR_W   = 10,
  parameter int RAM_DATA_W   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  wire                    i_clk,
  input  wire                    i_rst,
  nx_node_instr_arbiter_if.slave bus
`ifdef NX_INSTR_ARB_STATS_EN
  ,
  output logic [15:0]            o_stall_count
`endif
);

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  logic                  r_hold_full;
  logic                  r_hold_wr;
  logic [RAM_ADDR_W-1:0] r_hold_addr;
  logic [RAM_DATA_W-1:0] r_hold_data;
  logic [3:0]            r_starve;
  logic                  r_tag;
  logic [RAM_ADDR_W-1:0] r_last_addr;

  logic                  w_store_gnt;
  logic                  w_core_gnt;
  logic                  w_ready;
  logic                  w_accept;
  logic [RAM_ADDR_W-1:0] w_ram_addr;

  // Grants are masked during reset so a request held at reset never strobes.
  always_comb begin
    w_store_gnt = !i_rst && r_hold_full &&
                  (!bus.i_core_rd_en || (r_starve == c_starve_limit));
    w_core_gnt  = !i_rst && bus.i_core_rd_en && !w_store_gnt;
    w_ready     = !i_rst && !r_hold_full;
    w_accept    = bus.i_store_valid && w_ready;
    w_ram_addr  = r_last_addr;
    if (w_core_gnt)
      w_ram_addr = bus.i_core_addr;
    else if (w_store_gnt)
      w_ram_addr = r_hold_addr;
  end

  assign bus.o_core_stall     = bus.i_core_rd_en && w_store_gnt;
  assign bus.o_store_ready    = w_ready;
  assign bus.o_ram_addr       = w_ram_addr;
  assign bus.o_ram_wr_data    = r_hold_data;
  assign bus.o_ram_wr_en      = w_store_gnt && r_hold_wr;
  assign bus.o_ram_rd_en      = w_core_gnt || (w_store_gnt && !r_hold_wr);
  assign bus.o_core_rd_data   = bus.i_ram_rd_data;
  assign bus.o_store_rd_data  = bus.i_ram_rd_data;
  assign bus.o_store_rd_valid = r_tag;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold_full <= 1'b0;
      r_hold_wr   <= 1'b0;
      r_starve    <= 4'd0;
      r_tag       <= 1'b0;
      r_last_addr <= '0;
    end else begin
      r_tag       <= w_store_gnt && !r_hold_wr;
      r_last_addr <= w_ram_addr;

      if (w_store_gnt) begin
        r_hold_full <= 1'b0;
      end else if (w_accept) begin
        r_hold_full <= 1'b1;
        r_hold_wr   <= bus.i_store_wr;
      end

      if (!r_hold_full || w_store_gnt)
        r_starve <= 4'd0;
      else if (r_starve != c_starve_limit)
        r_starve <= r_starve + 4'd1;
    end
  end

  // Payload registers carry no reset; they are only consumed while full.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_hold_addr <= bus.i_store_addr;
      r_hold_data <= bus.i_store_wr_data;
    end
  end

`ifdef NX_INSTR_ARB_STATS_EN
  logic [15:0] r_stall_count;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_stall_count <= 16'd0;
    else if (bus.o_core_stall && (r_stall_count != 16'hFFFF))
      r_stall_count <= r_stall_count + 16'd1;
  end

  assign o_stall_count = r_stall_count;
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_nx_node_instr_arbiter.sv
// tb_nx_node_instr_arbiter: directed scoreboard bench for the instruction
// RAM arbiter, with a behavioural 1-cycle-latency RAM.
`default_nettype none

module tb_nx_node_instr_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nx_node_instr_arbiter_if #(.RAM_ADDR_W(AW), .RAM_DATA_W(DW)) bus ();

`ifdef NX_INSTR_ARB_STATS_EN
  logic [15:0] stall_count;
`endif

  nx_node_instr_arbiter #(.RAM_ADDR_W(AW), .RAM_DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
`ifdef NX_INSTR_ARB_STATS_EN
    ,
    .o_stall_count (stall_count)
`endif
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.o_ram_wr_en) mem[bus.o_ram_addr] <= bus.o_ram_wr_data;
    if (bus.o_ram_rd_en) bus.i_ram_rd_data <= mem[bus.o_ram_addr];
  end

  int vectors = 0;
  int miscompares = 0;
  logic [AW-1:0] exp_wr_addr_q [$];
  logic [DW-1:0] exp_wr_data_q [$];
  logic [DW-1:0] exp_rd_q [$];

  function automatic void check(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  // Scoreboard: RAM writes and store readbacks are matched against queued expectations.
  always @(negedge clk) begin
    if (!rst) begin
      check("strobe_excl", 64'(bus.o_ram_wr_en & bus.o_ram_rd_en), 64'd0);
      if (bus.o_ram_wr_en) begin
        if (exp_wr_addr_q.size() == 0) begin
          check("unexpected_write", 64'(bus.o_ram_wr_en), 64'd0);
        end else begin
          check("wr_addr", 64'(bus.o_ram_addr), 64'(exp_wr_addr_q.pop_front()));
          check("wr_data", 64'(bus.o_ram_wr_data), 64'(exp_wr_data_q.pop_front()));
        end
      end
      if (bus.o_store_rd_valid) begin
        if (exp_rd_q.size() == 0)
          check("unexpected_rdback", 64'(bus.o_store_rd_valid), 64'd0);
        else
          check("rd_data", 64'(bus.o_store_rd_data), 64'(exp_rd_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Held write under continuous core fetch: forced through after STARVE_LIMIT losses.
  task automatic starve_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.i_core_rd_en    = 1'b1;
    bus.i_core_addr     = 10'h020;
    bus.i_store_valid   = 1'b1;
    bus.i_store_wr      = 1'b1;
    bus.i_store_addr    = a;
    bus.i_store_wr_data = d;
    exp_wr_addr_q.push_back(a);
    exp_wr_data_q.push_back(d);
    sample();
    check("starve_accept_ready", 64'(bus.o_store_ready), 64'd1);
    check("starve_stall_n", 64'(bus.o_core_stall), 64'd0);
    tick();
    bus.i_store_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      sample();
      check("starve_wait_stall", 64'(bus.o_core_stall), 64'd0);
      check("starve_wait_wr", 64'(bus.o_ram_wr_en), 64'd0);
      tick();
    end
    sample();
    check("starve_grant_stall", 64'(bus.o_core_stall), 64'd1);
    check("starve_grant_wr", 64'(bus.o_ram_wr_en), 64'd1);
    tick();
    sample();
    check("starve_after_stall", 64'(bus.o_core_stall), 64'd0);
    check("starve_after_core_rd", 64'(bus.o_ram_rd_en), 64'd1);
    tick();
    bus.i_core_rd_en = 1'b0;
  endtask

  initial begin
    bus.i_core_addr     = '0;
    bus.i_core_rd_en    = 1'b0;
    bus.i_store_addr    = '0;
    bus.i_store_wr_data = '0;
    bus.i_store_wr      = 1'b0;
    bus.i_store_valid   = 1'b0;

    // Reset state
    repeat (3) begin
      sample();
      check("rst_ready", 64'(bus.o_store_ready), 64'd0);
      check("rst_stall", 64'(bus.o_core_stall), 64'd0);
      check("rst_rd_valid", 64'(bus.o_store_rd_valid), 64'd0);
    end
    tick();
    rst = 1'b0;
    sample();
    check("post_rst_ready", 64'(bus.o_store_ready), 64'd1);
    tick();

    // Core-only fetch
    for (int a = 0; a < 8; a++) begin
      bus.i_core_rd_en = 1'b1;
      bus.i_core_addr  = 10'(a);
      sample();
      check("core_stall", 64'(bus.o_core_stall), 64'd0);
      check("core_addr", 64'(bus.o_ram_addr), 64'(a));
      check("core_rd_en", 64'(bus.o_ram_rd_en), 64'd1);
      tick();
    end
    bus.i_core_rd_en = 1'b0;

    // Store write with idle core: write lands at N+1, ready low one cycle
    bus.i_store_valid   = 1'b1;
    bus.i_store_wr      = 1'b1;
    bus.i_store_addr    = 10'h005;
    bus.i_store_wr_data = 32'hDEADBEEF;
    exp_wr_addr_q.push_back(10'h005);
    exp_wr_data_q.push_back(32'hDEADBEEF);
    sample();
    check("wr_accept_ready", 64'(bus.o_store_ready), 64'd1);
    check("wr_n_wr_en", 64'(bus.o_ram_wr_en), 64'd0);
    tick();
    bus.i_store_valid = 1'b0;
    sample();
    check("wr_n1_wr_en", 64'(bus.o_ram_wr_en), 64'd1);
    check("wr_n1_ready", 64'(bus.o_store_ready), 64'd0);
    tick();
    sample();
    check("wr_n2_ready", 64'(bus.o_store_ready), 64'd1);
    check("wr_n2_wr_en", 64'(bus.o_ram_wr_en), 64'd0);
    tick();

    // Starvation under continuous fetch
    starve_write(10'h007, 32'hA5A50007);

    // Store readback: load 0x3 then read it back
    bus.i_store_valid   = 1'b1;
    bus.i_store_wr      = 1'b1;
    bus.i_store_addr    = 10'h003;
    bus.i_store_wr_data = 32'h12345678;
    exp_wr_addr_q.push_back(10'h003);
    exp_wr_data_q.push_back(32'h12345678);
    tick();
    bus.i_store_valid = 1'b0;
    tick();
    tick();
    bus.i_store_valid = 1'b1;
    bus.i_store_wr    = 1'b0;
    bus.i_store_addr  = 10'h003;
    exp_rd_q.push_back(32'h12345678);
    tick();
    bus.i_store_valid = 1'b0;
    sample();
    check("rd_grant_rd_en", 64'(bus.o_ram_rd_en), 64'd1);
    check("rd_grant_addr", 64'(bus.o_ram_addr), 64'h3);
    check("rd_grant_valid", 64'(bus.o_store_rd_valid), 64'd0);
    tick();
    sample();
    check("rd_pulse", 64'(bus.o_store_rd_valid), 64'd1);
    tick();
    sample();
    check("rd_pulse_end", 64'(bus.o_store_rd_valid), 64'd0);

    // Core fetch of the same word must not be tagged as store readback
    bus.i_core_rd_en = 1'b1;
    bus.i_core_addr  = 10'h003;
    tick();
    bus.i_core_rd_en = 1'b0;
    tick();
    bus.i_core_rd_en = 1'b0;
    sample();
    check("core_tag_data", 64'(bus.o_core_rd_data), 64'h12345678);
    check("core_tag_valid", 64'(bus.o_store_rd_valid), 64'd0);
    tick();

    // Reset while a write is held with the starve counter at 3
    bus.i_core_rd_en    = 1'b1;
    bus.i_core_addr     = 10'h040;
    bus.i_store_valid   = 1'b1;
    bus.i_store_wr      = 1'b1;
    bus.i_store_addr    = 10'h00A;
    bus.i_store_wr_data = 32'hBAD0BAD0;
    tick();
    bus.i_store_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    bus.i_core_rd_en = 1'b0;
    sample();
    check("mid_rst_wr_en", 64'(bus.o_ram_wr_en), 64'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      check("post_mid_rst_ready", 64'(bus.o_store_ready), 64'd1);
      check("post_mid_rst_wr_en", 64'(bus.o_ram_wr_en), 64'd0);
      check("post_mid_rst_rd_valid", 64'(bus.o_store_rd_valid), 64'd0);
      tick();
    end

`ifdef NX_INSTR_ARB_STATS_EN
    check("stats_reset", 64'(stall_count), 64'd0);
    starve_write(10'h011, 32'h00000011);
    starve_write(10'h012, 32'h00000012);
    starve_write(10'h013, 32'h00000013);
    sample();
    check("stats_three", 64'(stall_count), 64'd3);
    tick();
    force dut.r_stall_count = 16'hFFFF;
    tick();
    release dut.r_stall_count;
    starve_write(10'h014, 32'h00000014);
    sample();
    check("stats_saturate", 64'(stall_count), 64'hFFFF);
    tick();
`endif

    repeat (3) tick();
    check("wr_queue_empty", 64'(exp_wr_addr_q.size()), 64'd0);
    check("rd_queue_empty", 64'(exp_rd_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
